// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types for the memory refill arbiter: burst owner and arbiter state,
// plus the grant decision used when both caches compete for the port.
package mem_refill_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_I    = 2'd1,
        OWNER_D    = 2'd2
    } arb_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CMD  = 2'd1,
        ARB_DATA = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

    // D wins ties unless the I-cache has waited through the full starvation window.
    function automatic logic d_wins(input logic i_req, input logic d_req, input logic starved);
        return d_req && !(i_req && starved);
    endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Beat counter for one fixed-length burst: synchronous clear, increment,
// and a flag marking the final beat.
module mem_beat_counter #(
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(BURST_LEN)-1:0] cnt,
    output logic                         last
);

    localparam int CW = $clog2(BURST_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(BURST_LEN - 1));

endmodule

// File: rtl/mem_refill_arbiter.sv
// Arbitrates the external memory port between I-cache refills and D-cache
// refills/writebacks, one whole burst at a time, with D priority and I starvation relief.
module mem_refill_arbiter
    import mem_refill_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wnext,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic                  mem_cmd_we,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  arb_busy
);

    // Handshakes: mem_cmd and mem_w transfer on the cycle where valid and ready
    // are both high; valid and its payload stay stable until then. mem_rvalid
    // has no backpressure, so each read beat is forwarded in the cycle it arrives.

    localparam int BCW = $clog2(BURST_LEN);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state, state_d;
    arb_owner_t            owner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [SCW-1:0]        starve_cnt;
    logic                  starved;
    logic                  grant_i, grant_d;
    logic                  beat_clear, beat_inc, beat_last;
    logic [BCW-1:0]        beat_cnt;

    assign starved = (starve_cnt == SCW'(STARVE_LIMIT));

    mem_beat_counter #(
        .BURST_LEN(BURST_LEN)
    ) u_beat_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(beat_clear),
        .inc  (beat_inc),
        .cnt  (beat_cnt),
        .last (beat_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= OWNER_NONE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state <= state_d;
            if (grant_d || grant_i) begin
                owner  <= grant_d ? OWNER_D : OWNER_I;
                addr_q <= grant_d ? d_addr : i_addr;
                we_q   <= grant_d & d_we;
                // Only a D grant that leaves I waiting counts toward starvation.
                if (grant_d && i_req) begin
                    if (!starved) starve_cnt <= starve_cnt + 1'b1;
                end else begin
                    starve_cnt <= '0;
                end
            end else if (state == ARB_DONE) begin
                owner <= OWNER_NONE;
            end
        end
    end

    always_comb begin
        state_d       = state;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        beat_clear    = 1'b0;
        beat_inc      = 1'b0;
        i_rvalid      = 1'b0;
        i_done        = 1'b0;
        d_wnext       = 1'b0;
        d_rvalid      = 1'b0;
        d_done        = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_wvalid    = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (d_wins(i_req, d_req, starved)) begin
                    grant_d = 1'b1;
                    state_d = ARB_CMD;
                end else if (i_req) begin
                    grant_i = 1'b1;
                    state_d = ARB_CMD;
                end
            end
            ARB_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    beat_clear = 1'b1;
                    state_d    = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (we_q) begin
                    mem_wvalid = 1'b1;
                    if (mem_wready) begin
                        d_wnext  = 1'b1;
                        beat_inc = 1'b1;
                        d_done   = beat_last;
                        if (beat_last) state_d = ARB_DONE;
                    end
                end else if (mem_rvalid) begin
                    i_rvalid = (owner == OWNER_I);
                    d_rvalid = (owner == OWNER_D);
                    beat_inc = 1'b1;
                    i_done   = beat_last && (owner == OWNER_I);
                    d_done   = beat_last && (owner == OWNER_D);
                    if (beat_last) state_d = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Data paths are gated so every output reads zero outside its active window.
    assign i_rdata      = i_rvalid ? mem_rdata : '0;
    assign d_rdata      = d_rvalid ? mem_rdata : '0;
    assign mem_cmd_addr = mem_cmd_valid ? addr_q : '0;
    assign mem_cmd_we   = mem_cmd_valid & we_q;
    assign mem_wdata    = mem_wvalid ? d_wdata : '0;
    assign arb_busy     = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: directed scenarios plus a
// randomized run scored against a burst-level reference model.
`timescale 1ns/1ps
module tb_mem_refill_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int SL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req, i_rvalid, i_done;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_wnext, d_rvalid, d_done;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic          mem_wvalid, mem_wready, mem_rvalid, arb_busy;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    mem_refill_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_we(mem_cmd_we), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    logic [136:0] all_out;
    assign all_out = {i_rvalid, i_rdata, i_done, d_wnext, d_rvalid, d_rdata, d_done,
                      mem_cmd_valid, mem_cmd_addr, mem_cmd_we, mem_wvalid, mem_wdata, arb_busy};

    // ---------------- clock/reset and driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_cmd_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
        d_wdata = $urandom; mem_cmd_ready = 1'b1; mem_wready = 1'b1;
        #1;
        checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", all_out); end
        step();
        checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs_held: got %h exp 0", all_out); end
        checks++; if (dut.starve_cnt !== 2'd0) begin errors++; $display("FAIL reset_starve: got %0d exp 0", dut.starve_cnt); end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        checks++; if (all_out !== '0) begin errors++; $display("FAIL idle_outputs: got %h exp 0", all_out); end
        step();
        checks++; if (all_out !== '0) begin errors++; $display("FAIL idle_outputs_next: got %h exp 0", all_out); end
    endtask

    task automatic test_single_i_refill();
        idle_inputs();
        i_req = 1'b1; i_addr = 32'h0000_0100; mem_cmd_ready = 1'b1;
        #1;
        checks++; if ({mem_cmd_valid, arb_busy} !== 2'b00) begin errors++; $display("FAIL single_i_c0: got %b exp 00", {mem_cmd_valid, arb_busy}); end
        step();
        checks++; if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr} !== {2'b10, 32'h0000_0100}) begin
            errors++; $display("FAIL single_i_cmd: got %b %b %h exp 1 0 00000100", mem_cmd_valid, mem_cmd_we, mem_cmd_addr); end
        step();
        for (int k = 0; k < BL; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA0 + k;
            #1;
            checks++; if ({i_rvalid, i_rdata, i_done, d_rvalid} !== {1'b1, 32'hA0 + k, (k == BL - 1), 1'b0}) begin
                errors++; $display("FAIL single_i_beat%0d: got v=%b d=%h done=%b dv=%b exp 1 %h %0d 0", k, i_rvalid, i_rdata, i_done, d_rvalid, 32'hA0 + k, (k == BL - 1)); end
            step();
        end
        i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if ({arb_busy, i_rvalid, i_done, d_rvalid} !== 4'b1000) begin errors++; $display("FAIL single_i_done_cycle: got %b exp 1000", {arb_busy, i_rvalid, i_done, d_rvalid}); end
        step();
        checks++; if ({arb_busy, i_rvalid, d_rvalid, mem_cmd_valid} !== 4'b0000) begin errors++; $display("FAIL single_i_idle_c7: got %b exp 0000", {arb_busy, i_rvalid, d_rvalid, mem_cmd_valid}); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h2000; d_addr = 32'h3000; mem_cmd_ready = 1'b1;
        step();
        checks++; if ({mem_cmd_valid, mem_cmd_addr} !== {1'b1, 32'h3000}) begin errors++; $display("FAIL simul_d_first: got %b %h exp 1 00003000", mem_cmd_valid, mem_cmd_addr); end
        checks++; if (dut.starve_cnt !== 2'd1) begin errors++; $display("FAIL simul_starve_1: got %0d exp 1", dut.starve_cnt); end
        step();
        for (int k = 0; k < BL; k++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            #1;
            checks++; if ({i_rvalid, d_rvalid, d_done, d_rdata} !== {2'b01, (k == BL - 1), mem_rdata}) begin
                errors++; $display("FAIL simul_d_beat%0d: got iv=%b dv=%b done=%b d=%h", k, i_rvalid, d_rvalid, d_done, d_rdata); end
            step();
        end
        d_req = 1'b0; mem_rvalid = 1'b0;
        #1;
        checks++; if ({arb_busy, mem_cmd_valid} !== 2'b10) begin errors++; $display("FAIL simul_done_cycle: got %b exp 10", {arb_busy, mem_cmd_valid}); end
        step();
        checks++; if ({arb_busy, mem_cmd_valid} !== 2'b00) begin errors++; $display("FAIL simul_idle_cycle: got %b exp 00", {arb_busy, mem_cmd_valid}); end
        step();
        checks++; if ({mem_cmd_valid, mem_cmd_addr} !== {1'b1, 32'h2000}) begin errors++; $display("FAIL simul_i_second: got %b %h exp 1 00002000", mem_cmd_valid, mem_cmd_addr); end
        checks++; if (dut.starve_cnt !== 2'd0) begin errors++; $display("FAIL simul_starve_0: got %0d exp 0", dut.starve_cnt); end
        step();
        for (int k = 0; k < BL; k++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            #1;
            checks++; if ({i_rvalid, d_rvalid, i_done} !== {2'b10, (k == BL - 1)}) begin
                errors++; $display("FAIL simul_i_beat%0d: got iv=%b dv=%b done=%b", k, i_rvalid, d_rvalid, i_done); end
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_writeback_stall();
        logic [DW-1:0] w[BL];
        int idx = 0, wn = 0, dn = 0;
        idle_inputs();
        for (int k = 0; k < BL; k++) w[k] = $urandom;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = w[0]; mem_cmd_ready = 1'b1;
        step();
        checks++; if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr} !== {2'b11, 32'h4000}) begin
            errors++; $display("FAIL wb_cmd: got %b %b %h exp 1 1 00004000", mem_cmd_valid, mem_cmd_we, mem_cmd_addr); end
        step();
        for (int c = 0; c < 20; c++) begin
            mem_wready = c[0];
            d_wdata = w[idx & (BL - 1)];
            #1;
            checks++; if ({mem_wvalid, mem_wdata, d_wnext, d_done} !== {1'b1, w[idx & (BL - 1)], mem_wready, mem_wready && (idx == BL - 1)}) begin
                errors++; $display("FAIL wb_beat_c%0d: got wv=%b wd=%h wn=%b done=%b exp 1 %h %b %0d", c, mem_wvalid, mem_wdata, d_wnext, d_done, w[idx & (BL - 1)], mem_wready, mem_wready && (idx == BL - 1)); end
            if (d_wnext) begin idx++; wn++; end
            if (d_done) dn++;
            step();
            if (dn != 0) break;
        end
        checks++; if (wn !== BL) begin errors++; $display("FAIL wb_wnext_count: got %0d exp %0d", wn, BL); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL wb_done_count: got %0d exp 1", dn); end
        d_req = 1'b0; mem_wready = 1'b1;
        #1;
        checks++; if ({arb_busy, mem_wvalid, d_wnext} !== 3'b100) begin errors++; $display("FAIL wb_done_cycle: got %b exp 100", {arb_busy, mem_wvalid, d_wnext}); end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_cmd_stall();
        idle_inputs();
        i_req = 1'b1; i_addr = 32'h5000;
        step();
        for (int c = 0; c < 10; c++) begin
            mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            #1;
            checks++; if ({mem_cmd_valid, mem_cmd_addr, i_rvalid, d_rvalid, i_done, d_done} !== {1'b1, 32'h5000, 4'b0000}) begin
                errors++; $display("FAIL cmd_stall_c%0d: got cv=%b a=%h iv=%b dv=%b", c, mem_cmd_valid, mem_cmd_addr, i_rvalid, d_rvalid); end
            step();
        end
        mem_cmd_ready = 1'b1; mem_rvalid = 1'b0;
        step();
        for (int k = 0; k < BL; k++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            #1;
            checks++; if ({i_rvalid, i_rdata, i_done} !== {1'b1, mem_rdata, (k == BL - 1)}) begin
                errors++; $display("FAIL cmd_stall_beat%0d: got v=%b d=%h done=%b", k, i_rvalid, i_rdata, i_done); end
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_starvation();
        logic [1:0] got[4];
        int g = 0;
        bit fin = 1'b0;
        idle_inputs();
        for (int k = 0; k < 4; k++) got[k] = 2'd0;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h6000; d_addr = 32'h7000;
        mem_cmd_ready = 1'b1; mem_rvalid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            mem_rdata = $urandom;
            #1;
            if (mem_cmd_valid && g < 4) begin
                got[g] = (mem_cmd_addr == 32'h7000) ? 2'd2 : 2'd1;
                g++;
            end
            if (g == 4 && d_done) begin fin = 1'b1; break; end
            step();
        end
        checks++; if ({got[0], got[1], got[2], got[3]} !== {2'd2, 2'd2, 2'd1, 2'd2}) begin
            errors++; $display("FAIL starve_order: got %0d %0d %0d %0d exp 2 2 1 2 (2=D 1=I)", got[0], got[1], got[2], got[3]); end
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL starve_timeout: fourth burst done=%b exp 1", fin); end
        step();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        int dn = 0;
        idle_inputs();
        d_req = 1'b1; d_addr = 32'h8000; mem_cmd_ready = 1'b1;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            step();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0002;
        #1;
        checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'hCAFE_0002}) begin errors++; $display("FAIL rst_mid_beat2: got %b %h exp 1 cafe0002", d_rvalid, d_rdata); end
        rst_n = 1'b0;
        #1;
        checks++; if (all_out !== '0) begin errors++; $display("FAIL rst_mid_drop: got %h exp 0", all_out); end
        for (int c = 0; c < 3; c++) begin
            step();
            if (d_done) dn++;
            checks++; if (all_out !== '0) begin errors++; $display("FAIL rst_mid_hold_c%0d: got %h exp 0", c, all_out); end
        end
        mem_rvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if ({arb_busy, mem_cmd_valid, dn[0]} !== 3'b000) begin errors++; $display("FAIL rst_mid_release: got busy=%b cv=%b dn=%0d exp 0 0 0", arb_busy, mem_cmd_valid, dn); end
        step();
        checks++; if ({mem_cmd_valid, mem_cmd_addr} !== {1'b1, 32'h8000}) begin errors++; $display("FAIL rst_mid_regrant: got %b %h exp 1 00008000", mem_cmd_valid, mem_cmd_addr); end
        step();
        for (int k = 0; k < BL; k++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            #1;
            checks++; if ({d_rvalid, d_done} !== {1'b1, (k == BL - 1)}) begin errors++; $display("FAIL rst_mid_after_beat%0d: got dv=%b done=%b", k, d_rvalid, d_done); end
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    // Reference model tracks each burst as: waiting for grant, command offered,
    // beats outstanding, trailing gap; grants follow the priority/starvation rule.
    task automatic test_random();
        int phase = 0, owner = 0, beats = 0, starve = 0, d_idx = 0;
        logic [AW-1:0] m_addr = '0, ia = '0, da = '0;
        logic m_we = 1'b0, i_pend = 1'b0, d_pend = 1'b0, dwe_r = 1'b0;
        logic rbeat, wbeat, last;
        logic [DW-1:0] dw[BL];
        logic [DW-1:0] exp_w;
        for (int k = 0; k < BL; k++) dw[k] = '0;
        exp_q.delete();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (!i_pend && $urandom_range(0, 3) == 0) begin
                i_pend = 1'b1; ia = $urandom & 32'hFFFF_FFF0;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; da = $urandom & 32'hFFFF_FFF0; dwe_r = 1'($urandom_range(0, 1)); d_idx = 0;
                for (int k = 0; k < BL; k++) dw[k] = $urandom;
            end
            i_req = i_pend; i_addr = ia; d_req = d_pend; d_addr = da; d_we = dwe_r;
            d_wdata = (d_pend && d_idx < BL) ? dw[d_idx] : $urandom;
            mem_cmd_ready = 1'($urandom_range(0, 1));
            mem_wready = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            rbeat = (phase == 2) && !m_we && mem_rvalid;
            wbeat = (phase == 2) && m_we && mem_wready;
            last = (rbeat || wbeat) && (beats == BL - 1);
            checks++; if ({mem_cmd_valid, arb_busy} !== {phase == 1, phase != 0}) begin
                errors++; $display("FAIL rand_cmd_busy c%0d: got %b%b exp %0d%0d", c, mem_cmd_valid, arb_busy, phase == 1, phase != 0); end
            if (phase == 1) begin
                checks++; if ({mem_cmd_addr, mem_cmd_we} !== {m_addr, m_we}) begin
                    errors++; $display("FAIL rand_cmd_payload c%0d: got %h %b exp %h %b", c, mem_cmd_addr, mem_cmd_we, m_addr, m_we); end
            end
            checks++; if ({i_rvalid, d_rvalid, i_done, d_done} !== {rbeat && owner == 0, rbeat && owner == 1, last && owner == 0, last && owner == 1}) begin
                errors++; $display("FAIL rand_read c%0d: got %b exp %b", c, {i_rvalid, d_rvalid, i_done, d_done}, {rbeat && owner == 0, rbeat && owner == 1, last && owner == 0, last && owner == 1}); end
            if (rbeat) begin
                checks++; if (((owner == 0) ? i_rdata : d_rdata) !== mem_rdata) begin
                    errors++; $display("FAIL rand_rdata c%0d: got %h exp %h", c, (owner == 0) ? i_rdata : d_rdata, mem_rdata); end
            end
            checks++; if ({mem_wvalid, d_wnext} !== {(phase == 2) && m_we, wbeat}) begin
                errors++; $display("FAIL rand_write c%0d: got %b%b exp %0d%0d", c, mem_wvalid, d_wnext, (phase == 2) && m_we, wbeat); end
            if (wbeat && exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                checks++; if (mem_wdata !== exp_w) begin errors++; $display("FAIL rand_wdata c%0d: got %h exp %h", c, mem_wdata, exp_w); end
            end
            case (phase)
                0: if (i_req || d_req) begin
                    owner = (d_req && !(i_req && starve == SL)) ? 1 : 0;
                    starve = (owner == 1 && i_req) ? ((starve < SL) ? starve + 1 : SL) : 0;
                    m_addr = (owner == 1) ? d_addr : i_addr;
                    m_we = (owner == 1) && d_we;
                    if (m_we) for (int k = 0; k < BL; k++) exp_q.push_back(dw[k]);
                    phase = 1;
                end
                1: if (mem_cmd_ready) begin phase = 2; beats = 0; end
                2: if (rbeat || wbeat) begin beats++; if (beats == BL) phase = 3; end
                default: phase = 0;
            endcase
            if (wbeat) d_idx++;
            if (last) begin
                if (owner == 0) i_pend = 1'b0; else d_pend = 1'b0;
            end
            step();
        end
        idle_inputs();
        do_reset();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_i_refill();
        test_simultaneous();
        test_writeback_stall();
        test_cmd_stall();
        test_starvation();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
